// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//   register-address width, FSM state encodings and the width of the
//   load-use hold counter.
//   The macros are guarded so that every file in the slice can provide the
//   same fallback definitions without clashing with one another.

`ifndef AWIDTH
`define AWIDTH 5
`endif
`ifndef HC_RUN
`define HC_RUN      2'd0
`define HC_LOAD_USE 2'd1
`define HC_REDIRECT 2'd2
`define HC_MEM_WAIT 2'd3
`endif

package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = `HC_RUN,
    ST_LOAD_USE = `HC_LOAD_USE,
    ST_REDIRECT = `HC_REDIRECT,
    ST_MEM_WAIT = `HC_MEM_WAIT
  } hc_state_e;

  // Holds LOAD_STALL_CYCLES-1, and LOAD_STALL_CYCLES is limited to 1..15.
  localparam int unsigned LU_CNT_W = 4;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// hazard_detect
//   Combinational load-use detector. Flags the case where the instruction in
//   ID reads a register that the load currently in EX has not produced yet.
//   Ports:
//     id_addr_rs, id_addr_rt : source registers of the ID instruction
//     id_uses_rt             : ID instruction actually reads rt
//     ex_memtoreg, ex_reg_wr : EX instruction is a load that writes the RF
//     ex_addr_wr             : EX destination register
//     load_use               : hazard present this cycle

`ifndef AWIDTH
`define AWIDTH 5
`endif

module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [`AWIDTH-1:0] id_addr_rs,
  input  logic [`AWIDTH-1:0] id_addr_rt,
  input  logic               id_uses_rt,
  input  logic               ex_memtoreg,
  input  logic               ex_reg_wr,
  input  logic [`AWIDTH-1:0] ex_addr_wr,
  output logic               load_use
);

  logic wr_valid_s;
  logic rs_hit_s;
  logic rt_hit_s;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  always_comb begin
    wr_valid_s = ex_memtoreg & ex_reg_wr & (ex_addr_wr != {`AWIDTH{1'b0}});
    rs_hit_s   = (ex_addr_wr == id_addr_rs);
    rt_hit_s   = id_uses_rt & (ex_addr_wr == id_addr_rt);
    load_use   = wr_valid_s & (rs_hit_s | rt_hit_s);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Decides, from the current
//   FSM state and this cycle's hazards, which stage registers hold, which are
//   cleared and whether the PC takes the redirect target. Controls are Mealy
//   outputs. A saturating counter records cycles in which the front end
//   (PC + IF/ID) was held.
//   Ports:
//     hc_clk, hc_rst                 : clock, synchronous active-high reset
//     hc_i_id_addr_rs/_rt/_uses_rt   : ID instruction source registers
//     hc_i_ex_memtoreg/_reg_wr/_addr_wr : EX instruction load/write info
//     hc_i_change_pc                 : taken branch/jump resolved in EX
//     hc_i_dmem_req, hc_i_dmem_ack   : data-memory access in flight / done
//     hc_o_stall_if/_id/_ex/_mem     : per-stage hold
//     hc_o_bubble_ex                 : insert NOP into ID/EX
//     hc_o_flush_id, hc_o_flush_ex   : clear IF/ID, ID/EX
//     hc_o_pc_sel                    : PC loads redirect target
//     hc_o_state                     : current FSM state
//     hc_o_stall_cnt                 : saturating front-end stall count

`ifndef AWIDTH
`define AWIDTH 5
`endif

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                 hc_clk,
  input  logic                 hc_rst,
  input  logic [`AWIDTH-1:0]   hc_i_id_addr_rs,
  input  logic [`AWIDTH-1:0]   hc_i_id_addr_rt,
  input  logic                 hc_i_id_uses_rt,
  input  logic                 hc_i_ex_memtoreg,
  input  logic                 hc_i_ex_reg_wr,
  input  logic [`AWIDTH-1:0]   hc_i_ex_addr_wr,
  input  logic                 hc_i_change_pc,
  input  logic                 hc_i_dmem_req,
  input  logic                 hc_i_dmem_ack,
  output logic                 hc_o_stall_if,
  output logic                 hc_o_stall_id,
  output logic                 hc_o_stall_ex,
  output logic                 hc_o_stall_mem,
  output logic                 hc_o_bubble_ex,
  output logic                 hc_o_flush_id,
  output logic                 hc_o_flush_ex,
  output logic                 hc_o_pc_sel,
  output logic [1:0]           hc_o_state,
  output logic [CNT_WIDTH-1:0] hc_o_stall_cnt
);

  localparam logic [LU_CNT_W-1:0]  LU_INIT = LU_CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [LU_CNT_W-1:0]  LU_ONE  = {{(LU_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  hc_state_e             state_r;
  hc_state_e             state_nxt_s;
  logic [LU_CNT_W-1:0]   cnt_r;
  logic [LU_CNT_W-1:0]   cnt_nxt_s;
  logic [CNT_WIDTH-1:0]  stall_cnt_r;

  logic load_use_s;
  logic mem_busy_s;
  logic stall_if_s;
  logic stall_id_s;
  logic stall_ex_s;
  logic stall_mem_s;
  logic bubble_ex_s;
  logic flush_id_s;
  logic flush_ex_s;
  logic pc_sel_s;
  logic [1:0] state_out_s;

  hazard_detect u_detect (
    .id_addr_rs  (hc_i_id_addr_rs),
    .id_addr_rt  (hc_i_id_addr_rt),
    .id_uses_rt  (hc_i_id_uses_rt),
    .ex_memtoreg (hc_i_ex_memtoreg),
    .ex_reg_wr   (hc_i_ex_reg_wr),
    .ex_addr_wr  (hc_i_ex_addr_wr),
    .load_use    (load_use_s)
  );

  assign mem_busy_s = hc_i_dmem_req & ~hc_i_dmem_ack;

  // Next-state and Mealy control decode; reset forces every control low.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_if_s  = 1'b0;
    stall_id_s  = 1'b0;
    stall_ex_s  = 1'b0;
    stall_mem_s = 1'b0;
    bubble_ex_s = 1'b0;
    flush_id_s  = 1'b0;
    flush_ex_s  = 1'b0;
    pc_sel_s    = 1'b0;
    state_out_s = state_r;
    if (hc_rst) begin
      state_nxt_s = ST_RUN;
      cnt_nxt_s   = {LU_CNT_W{1'b0}};
      state_out_s = `HC_RUN;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_busy_s) begin
            {stall_if_s, stall_id_s, stall_ex_s, stall_mem_s} = 4'b1111;
            state_nxt_s = ST_MEM_WAIT;
          end else if (hc_i_change_pc) begin
            // Redirect outranks a load-use: the dependent instruction is on
            // the wrong path and is being flushed anyway.
            pc_sel_s    = 1'b1;
            flush_id_s  = 1'b1;
            flush_ex_s  = 1'b1;
            state_nxt_s = ST_REDIRECT;
          end else if (load_use_s) begin
            stall_if_s  = 1'b1;
            stall_id_s  = 1'b1;
            bubble_ex_s = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_nxt_s = ST_LOAD_USE;
              cnt_nxt_s   = LU_INIT;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_LOAD_USE: begin
          if (mem_busy_s) begin
            // Whole pipe frozen: hold the remaining load-use count.
            {stall_if_s, stall_id_s, stall_ex_s, stall_mem_s} = 4'b1111;
          end else begin
            stall_if_s  = 1'b1;
            stall_id_s  = 1'b1;
            bubble_ex_s = 1'b1;
            cnt_nxt_s   = cnt_r - LU_ONE;
            if (cnt_r <= LU_ONE) begin
              state_nxt_s = ST_RUN;
            end else begin
              state_nxt_s = ST_LOAD_USE;
            end
          end
        end
        ST_REDIRECT: begin
          // The synchronous imem delivers one more wrong-path word after
          // the redirect; kill it here.
          flush_id_s = 1'b1;
          if (mem_busy_s) begin
            {stall_if_s, stall_id_s, stall_ex_s, stall_mem_s} = 4'b1111;
            state_nxt_s = ST_REDIRECT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          // Hazards seen here stay asserted while frozen and are handled
          // back in RUN.
          if (!hc_i_dmem_ack) begin
            {stall_if_s, stall_id_s, stall_ex_s, stall_mem_s} = 4'b1111;
            state_nxt_s = ST_MEM_WAIT;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = {LU_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, load-use counter and saturating stall counter.
  always_ff @(posedge hc_clk) begin
    if (hc_rst) begin
      state_r     <= ST_RUN;
      cnt_r       <= {LU_CNT_W{1'b0}};
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (stall_if_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign hc_o_stall_if  = stall_if_s;
  assign hc_o_stall_id  = stall_id_s;
  assign hc_o_stall_ex  = stall_ex_s;
  assign hc_o_stall_mem = stall_mem_s;
  assign hc_o_bubble_ex = bubble_ex_s;
  assign hc_o_flush_id  = flush_id_s;
  assign hc_o_flush_ex  = flush_ex_s;
  assign hc_o_pc_sel    = pc_sel_s;
  assign hc_o_state     = state_out_s;
  assign hc_o_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Scoreboard bench for hazard_ctrl. Two instances share stimulus: one with
//   a 1-cycle load-use hold, one with a 3-cycle hold. Expected control
//   vectors are written by hand per step and queued when the step is driven.

`ifndef AWIDTH
`define AWIDTH 5
`endif

module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       m2r;
    logic       rw;
    logic [4:0] wr;
    logic       cpc;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct {
    string       tag;
    logic [9:0]  e1;
    logic [9:0]  e3;
    bit          c1;
    bit          c3;
    logic [15:0] ecnt;
  } exp_t;

  // Control flags: {stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
  //                 flush_id, flush_ex, pc_sel}
  localparam logic [7:0] F_NONE = 8'b0000_0000;
  localparam logic [7:0] F_ALL  = 8'b1111_0000;
  localparam logic [7:0] F_LU   = 8'b1100_1000;
  localparam logic [7:0] F_RD   = 8'b0000_0111;
  localparam logic [7:0] F_FID  = 8'b0000_0100;
  localparam logic [7:0] F_AFID = 8'b1111_0100;
  localparam logic [1:0] S_RUN = 2'd0, S_LU = 2'd1, S_RD = 2'd2, S_MW = 2'd3;

  logic clk;
  logic rst;
  logic [`AWIDTH-1:0] rs, rt, wr;
  logic urt, m2r, rw, cpc, req, ack;

  logic si1, sd1, se1, sm1, bu1, fi1, fe1, pc1;
  logic si3, sd3, se3, sm3, bu3, fi3, fe3, pc3;
  logic [1:0]  st1, st3;
  logic [15:0] cnt1, cnt3;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_cnt = 16'd0;
  exp_t sb_q[$];

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .hc_clk(clk), .hc_rst(rst),
    .hc_i_id_addr_rs(rs), .hc_i_id_addr_rt(rt), .hc_i_id_uses_rt(urt),
    .hc_i_ex_memtoreg(m2r), .hc_i_ex_reg_wr(rw), .hc_i_ex_addr_wr(wr),
    .hc_i_change_pc(cpc), .hc_i_dmem_req(req), .hc_i_dmem_ack(ack),
    .hc_o_stall_if(si1), .hc_o_stall_id(sd1), .hc_o_stall_ex(se1),
    .hc_o_stall_mem(sm1), .hc_o_bubble_ex(bu1), .hc_o_flush_id(fi1),
    .hc_o_flush_ex(fe1), .hc_o_pc_sel(pc1), .hc_o_state(st1),
    .hc_o_stall_cnt(cnt1)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_WIDTH(16)) dut3 (
    .hc_clk(clk), .hc_rst(rst),
    .hc_i_id_addr_rs(rs), .hc_i_id_addr_rt(rt), .hc_i_id_uses_rt(urt),
    .hc_i_ex_memtoreg(m2r), .hc_i_ex_reg_wr(rw), .hc_i_ex_addr_wr(wr),
    .hc_i_change_pc(cpc), .hc_i_dmem_req(req), .hc_i_dmem_ack(ack),
    .hc_o_stall_if(si3), .hc_o_stall_id(sd3), .hc_o_stall_ex(se3),
    .hc_o_stall_mem(sm3), .hc_o_bubble_ex(bu3), .hc_o_flush_id(fi3),
    .hc_o_flush_ex(fe3), .hc_o_pc_sel(pc3), .hc_o_state(st3),
    .hc_o_stall_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] x(input logic [7:0] f, input logic [1:0] s);
    return {f, s};
  endfunction

  function automatic in_t mk(input logic r, input logic [4:0] a_rs,
                             input logic [4:0] a_rt, input logic a_urt,
                             input logic a_m2r, input logic a_rw,
                             input logic [4:0] a_wr, input logic a_cpc,
                             input logic a_req, input logic a_ack);
    in_t v;
    v.rst = r;   v.rs = a_rs; v.rt = a_rt; v.urt = a_urt; v.m2r = a_m2r;
    v.rw = a_rw; v.wr = a_wr; v.cpc = a_cpc; v.req = a_req; v.ack = a_ack;
    return v;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // Apply one cycle of inputs, queue its expectation, compare at negedge.
  task automatic step(input string tag, input in_t v,
                      input logic [9:0] e1, input logic [9:0] e3,
                      input bit c1, input bit c3);
    exp_t e;
    exp_t g;
    @(posedge clk);
    #1;
    rst = v.rst; rs = v.rs; rt = v.rt; urt = v.urt; m2r = v.m2r;
    rw = v.rw;   wr = v.wr; cpc = v.cpc; req = v.req; ack = v.ack;
    e.tag = tag; e.e1 = e1; e.e3 = e3; e.c1 = c1; e.c3 = c3;
    e.ecnt = exp_cnt;
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    if (g.c1) begin
      check_val({g.tag, "/ctl1"},
                {22'd0, si1, sd1, se1, sm1, bu1, fi1, fe1, pc1, st1}, {22'd0, g.e1});
      check_val({g.tag, "/cnt1"}, {16'd0, cnt1}, {16'd0, g.ecnt});
      if (g.e1[9] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    if (g.c3) begin
      check_val({g.tag, "/ctl3"},
                {22'd0, si3, sd3, se3, sm3, bu3, fi3, fe3, pc3, st3}, {22'd0, g.e3});
    end
    if (v.rst) exp_cnt = 16'd0;
  endtask

  in_t idle, rsti, haz2, z0, nrt, h5, cp, rq, ak, both, h5rq, h5ak, rstrq;
  logic [9:0] none_run;

  initial begin
    rst = 1'b1; rs = '0; rt = '0; urt = 1'b0; m2r = 1'b0; rw = 1'b0;
    wr = '0; cpc = 1'b0; req = 1'b0; ack = 1'b0;
    idle  = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rsti  = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    haz2  = mk(1'b0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    z0    = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    nrt   = mk(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    h5    = mk(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    h5rq  = mk(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
    h5ak  = mk(1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1);
    cp    = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    rq    = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    ak    = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    both  = mk(1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    rstrq = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    none_run = x(F_NONE, S_RUN);

    // Reset with hazards present: controls must stay low.
    step("rst", rsti, none_run, none_run, 1'b1, 1'b1);
    step("idle", idle, none_run, none_run, 1'b1, 1'b1);

    // lw $2 then use of $2 in rs: single stall cycle with 1-cycle hold.
    step("lu1_a", haz2, x(F_LU, S_RUN), none_run, 1'b1, 1'b0);
    step("lu1_b", idle, none_run, none_run, 1'b1, 1'b0);

    // Register 0 / unused rt never stall; 3-cycle hold on rt dependency.
    step("rst2", rsti, none_run, none_run, 1'b1, 1'b1);
    step("zero_reg", z0, none_run, none_run, 1'b1, 1'b1);
    step("no_rt", nrt, none_run, none_run, 1'b1, 1'b1);
    step("lu3_a", h5, x(F_LU, S_RUN), x(F_LU, S_RUN), 1'b1, 1'b1);
    step("lu3_b", h5, x(F_LU, S_RUN), x(F_LU, S_LU), 1'b1, 1'b1);
    step("lu3_c", h5, x(F_LU, S_RUN), x(F_LU, S_LU), 1'b1, 1'b1);
    step("lu3_d", idle, none_run, none_run, 1'b1, 1'b1);

    // Redirect: two flush_id cycles, one pc_sel/flush_ex cycle.
    step("rst3", rsti, none_run, none_run, 1'b1, 1'b1);
    step("rd_a", cp, x(F_RD, S_RUN), x(F_RD, S_RUN), 1'b1, 1'b1);
    step("rd_b", idle, x(F_FID, S_RD), x(F_FID, S_RD), 1'b1, 1'b1);
    step("rd_c", idle, none_run, none_run, 1'b1, 1'b1);

    // Memory wait of 4 cycles, then ack-in-first-cycle case.
    step("rst4", rsti, none_run, none_run, 1'b1, 1'b1);
    step("mw_1", rq, x(F_ALL, S_RUN), x(F_ALL, S_RUN), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("mw_n", rq, x(F_ALL, S_MW), x(F_ALL, S_MW), 1'b1, 1'b1);
    end
    step("mw_ack", ak, x(F_NONE, S_MW), x(F_NONE, S_MW), 1'b1, 1'b1);
    step("mw_done", idle, none_run, none_run, 1'b1, 1'b1);
    step("ack_fast", ak, none_run, none_run, 1'b1, 1'b1);
    step("ack_fast2", idle, none_run, none_run, 1'b1, 1'b1);

    // Redirect beats load-use; memory busy during REDIRECT holds it.
    step("rst5", rsti, none_run, none_run, 1'b1, 1'b1);
    step("both", both, x(F_RD, S_RUN), x(F_RD, S_RUN), 1'b1, 1'b1);
    step("rd_busy1", rq, x(F_AFID, S_RD), x(F_AFID, S_RD), 1'b1, 1'b1);
    step("rd_busy2", rq, x(F_AFID, S_RD), x(F_AFID, S_RD), 1'b1, 1'b1);
    step("rd_ack", ak, x(F_FID, S_RD), x(F_FID, S_RD), 1'b1, 1'b1);
    step("rd_end", idle, none_run, none_run, 1'b1, 1'b1);

    // Memory busy inside LOAD_USE freezes the hold count.
    step("rst6", rsti, none_run, none_run, 1'b1, 1'b1);
    step("lum_a", h5, x(F_LU, S_RUN), x(F_LU, S_RUN), 1'b1, 1'b1);
    step("lum_b", h5rq, x(F_ALL, S_RUN), x(F_ALL, S_LU), 1'b1, 1'b1);
    step("lum_c", h5ak, x(F_NONE, S_MW), x(F_LU, S_LU), 1'b1, 1'b1);
    step("lum_d", h5, x(F_LU, S_RUN), x(F_LU, S_LU), 1'b1, 1'b1);
    step("lum_e", idle, none_run, none_run, 1'b1, 1'b1);

    // Reset in the middle of MEM_WAIT.
    step("rst7", rsti, none_run, none_run, 1'b1, 1'b1);
    step("mr_a", rq, x(F_ALL, S_RUN), x(F_ALL, S_RUN), 1'b1, 1'b1);
    step("mr_b", rq, x(F_ALL, S_MW), x(F_ALL, S_MW), 1'b1, 1'b1);
    step("mr_rst", rstrq, none_run, none_run, 1'b1, 1'b1);
    step("mr_after", idle, none_run, none_run, 1'b1, 1'b1);

    // Saturation: 2^16+3 stall cycles in total.
    step("sat_a", rq, x(F_ALL, S_RUN), x(F_ALL, S_RUN), 1'b1, 1'b1);
    for (int i = 0; i < 65537; i++) begin
      @(posedge clk);
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    step("sat_b", rq, x(F_ALL, S_MW), x(F_ALL, S_MW), 1'b1, 1'b1);
    step("sat_ack", ak, x(F_NONE, S_MW), x(F_NONE, S_MW), 1'b1, 1'b1);
    step("sat_end", idle, none_run, none_run, 1'b1, 1'b1);
    check_val("sat_val", {16'd0, cnt1}, 32'h0000_FFFF);
    check_val("sat_val3", {16'd0, cnt3}, 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
